// File: rtl/calc_pkg.sv
// Shared types and helpers for the N-digit calculator core.
package calc_pkg;

  // Top-level operating state; encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_OPE   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Operation applied to the accumulator on the next operator/equal key.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Largest magnitude representable with the given number of decimal digits.
  function automatic int maxval(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter.
// A start pulse loads the value and performs the first shift in the same
// cycle; the remaining VAL_W-1 shifts follow, and the final shift writes bcd
// and pulses done. A start while busy abandons the current conversion.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int VAL_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W     = BCD_W + VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
  function automatic logic [W-1:0] dabble_step(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x;
    for (int d = 0; d < DIGITS; d++) begin
      if (y[VAL_W+4*d +: 4] >= 4'd5) y[VAL_W+4*d +: 4] = y[VAL_W+4*d +: 4] + 4'd3;
    end
    return y << 1;
  endfunction

  logic [W-1:0]     r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_bcd;
  logic [W-1:0]     w_next;

  assign w_next = dabble_step(r_work);

  // Load/shift sequencer; the result register only changes on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd  <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_work <= dabble_step({BCD_W'(0), bin});
        r_cnt  <= CNT_W'(VAL_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_work <= w_next;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_bcd  <= w_next[W-1:VAL_W];
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/calc_ndigit_core.sv
// N-digit signed decimal add/subtract calculator core.
// Consumes single-cycle key pulses, keeps the entry register and the signed
// accumulator, and presents the displayed magnitude as BCD via a sequential
// converter.
module calc_ndigit_core
  import calc_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dig_vld,
  input  logic [3:0]                    dig,
  input  logic                          plus,
  input  logic                          minus,
  input  logic                          equal,
  input  logic                          ce,
  output logic                          sign,
  output logic                          overflow,
  output logic [4*DIGITS-1:0]           disp_bcd,
  output logic                          bcd_vld,
  output logic [1:0]                    state,
  output logic [$clog2(DIGITS+1)-1:0]   dig_cnt
);

  localparam int VAL_W  = $clog2(10 ** DIGITS);
  localparam int ACC_W  = VAL_W + 2;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int MAXVAL = maxval(DIGITS);

  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAXVAL);
  localparam logic [VAL_W-1:0]        TEN   = VAL_W'(10);

  state_t                   r_state;
  logic [VAL_W-1:0]         r_rega;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_dig_cnt;
  op_t                      r_pend_op;
  logic                     r_eq_done;

  logic [VAL_W-1:0]         r_last_bin;
  logic [BCD_W-1:0]         r_disp_bcd;
  logic                     r_bcd_vld;

  logic                     w_op_key;
  logic                     w_dig_ok;
  logic signed [ACC_W-1:0]  w_rega_ext;
  logic signed [ACC_W-1:0]  w_res;
  logic                     w_res_ovf;
  op_t                      w_new_op;
  logic [VAL_W-1:0]         w_rega_shift;
  logic [VAL_W-1:0]         w_mag;
  logic                     w_sign;
  logic                     w_start;
  logic                     w_busy;
  logic                     w_done;
  logic [BCD_W-1:0]         w_bcd;

  assign w_op_key     = equal | minus | plus;
  assign w_dig_ok     = dig_vld && (dig <= 4'd9);
  assign w_rega_ext   = signed'({2'b00, r_rega});
  assign w_res        = (r_pend_op == OP_SUB) ? (r_acc - w_rega_ext) : (r_acc + w_rega_ext);
  assign w_res_ovf    = (w_res > MAX_S) || (w_res < -MAX_S);
  // minus outranks plus when both arrive together.
  assign w_new_op     = minus ? OP_SUB : OP_ADD;
  assign w_rega_shift = (r_rega * TEN) + VAL_W'(dig);

  // Calculator FSM: key decode with priority ce > equal > minus > plus > digit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_ENTRY;
      r_rega    <= '0;
      r_acc     <= '0;
      r_dig_cnt <= '0;
      r_pend_op <= OP_ADD;
      r_eq_done <= 1'b0;
    end else begin
      case (r_state)
        ST_ENTRY: begin
          if (ce) begin
            // Clear-entry: the accumulator survives.
            r_rega    <= '0;
            r_dig_cnt <= '0;
          end else if (w_op_key) begin
            if (w_res_ovf) begin
              r_state <= ST_HALT;
            end else begin
              r_acc   <= w_res;
              r_state <= ST_OPE;
              if (equal) r_eq_done <= 1'b1;
              else       r_pend_op <= w_new_op;
            end
          end else if (w_dig_ok && (r_dig_cnt < CNT_W'(DIGITS))) begin
            r_rega    <= w_rega_shift;
            r_dig_cnt <= r_dig_cnt + CNT_W'(1);
          end
        end

        ST_OPE: begin
          if (ce) begin
            r_acc     <= '0;
            r_rega    <= '0;
            r_dig_cnt <= '0;
            r_pend_op <= OP_ADD;
            r_eq_done <= 1'b0;
            r_state   <= ST_ENTRY;
          end else if (equal) begin
            // Repeated '=' leaves the result on display untouched.
          end else if (minus || plus) begin
            // Operator replacement: no accumulation happens here.
            r_pend_op <= w_new_op;
            r_eq_done <= 1'b0;
          end else if (w_dig_ok) begin
            r_rega    <= VAL_W'(dig);
            r_dig_cnt <= CNT_W'(1);
            r_state   <= ST_ENTRY;
            // A digit straight after '=' starts a fresh calculation.
            if (r_eq_done) begin
              r_acc     <= '0;
              r_pend_op <= OP_ADD;
              r_eq_done <= 1'b0;
            end
          end
        end

        ST_HALT: begin
          if (ce) begin
            r_acc     <= '0;
            r_rega    <= '0;
            r_dig_cnt <= '0;
            r_pend_op <= OP_ADD;
            r_eq_done <= 1'b0;
            r_state   <= ST_ENTRY;
          end
        end

        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  // Display mux: entry register while typing, |acc| with sign after an operator.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    case (r_state)
      ST_ENTRY: w_mag = r_rega;
      ST_OPE: begin
        w_mag  = VAL_W'(r_acc[ACC_W-1] ? -r_acc : r_acc);
        w_sign = r_acc[ACC_W-1];
      end
      default: begin
        w_mag  = '0;
        w_sign = 1'b0;
      end
    endcase
  end

  // A new conversion is launched whenever the shown magnitude moves away
  // from the last value handed to the converter.
  assign w_start = (w_mag != r_last_bin);

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (w_mag),
    .busy  (w_busy),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  // BCD display register: held until a conversion finishes with no newer start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_bin <= '0;
      r_disp_bcd <= '0;
      r_bcd_vld  <= 1'b1;
    end else if (w_start) begin
      r_last_bin <= w_mag;
      r_bcd_vld  <= 1'b0;
    end else if (w_done && !w_busy) begin
      r_disp_bcd <= w_bcd;
      r_bcd_vld  <= 1'b1;
    end
  end

  assign sign     = w_sign;
  assign overflow = (r_state == ST_HALT);
  assign disp_bcd = r_disp_bcd;
  assign bcd_vld  = r_bcd_vld;
  assign state    = r_state;
  assign dig_cnt  = r_dig_cnt;

endmodule

// File: tb/tb_calc_ndigit_core.sv
// Directed bench for calc_ndigit_core: a 3-digit and a 4-digit instance share
// the key inputs; vector tables drive one key per step and compare the
// settled outputs, and hand-written sequences cover conversion timing,
// mid-conversion restart and asynchronous reset.
module tb_calc_ndigit_core;

  localparam logic [4:0] K_D  = 5'b00001;
  localparam logic [4:0] K_P  = 5'b00010;
  localparam logic [4:0] K_M  = 5'b00100;
  localparam logic [4:0] K_EQ = 5'b01000;
  localparam logic [4:0] K_CE = 5'b10000;

  localparam logic [1:0] E = 2'd0;
  localparam logic [1:0] O = 2'd1;
  localparam logic [1:0] H = 2'd2;

  typedef struct {
    logic [4:0]  keys;   // {ce, equal, minus, plus, dig_vld}
    logic [3:0]  dig;
    logic [1:0]  st;
    logic [2:0]  cnt;
    logic        sg;
    logic        ov;
    logic [15:0] bcd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dig_vld = 1'b0;
  logic [3:0] dig = 4'd0;
  logic plus = 1'b0, minus = 1'b0, equal = 1'b0, ce = 1'b0;

  logic        sign3, ovf3, vld3;
  logic [11:0] bcd3;
  logic [1:0]  st3;
  logic [1:0]  cnt3;
  logic        sign4, ovf4, vld4;
  logic [15:0] bcd4;
  logic [1:0]  st4;
  logic [2:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;
  vec_t v3[$];
  vec_t v4[$];

  always #5 clk = ~clk;

  calc_ndigit_core #(.DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .dig_vld(dig_vld), .dig(dig),
    .plus(plus), .minus(minus), .equal(equal), .ce(ce),
    .sign(sign3), .overflow(ovf3), .disp_bcd(bcd3), .bcd_vld(vld3),
    .state(st3), .dig_cnt(cnt3)
  );

  calc_ndigit_core #(.DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .dig_vld(dig_vld), .dig(dig),
    .plus(plus), .minus(minus), .equal(equal), .ce(ce),
    .sign(sign4), .overflow(ovf4), .disp_bcd(bcd4), .bcd_vld(vld4),
    .state(st4), .dig_cnt(cnt4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input bit four, input logic [4:0] k, input logic [3:0] d,
                     input logic [1:0] st, input int cnt, input logic sg,
                     input logic ov, input logic [15:0] bcd);
    vec_t v;
    v.keys = k; v.dig = d; v.st = st; v.cnt = 3'(cnt); v.sg = sg; v.ov = ov; v.bcd = bcd;
    if (four) v4.push_back(v);
    else      v3.push_back(v);
  endtask

  // One key pulse, launched at a falling edge and held for one rising edge.
  task automatic press(input logic [4:0] k, input logic [3:0] d);
    @(negedge clk);
    {ce, equal, minus, plus, dig_vld} = k;
    dig = d;
    @(posedge clk);
    #1;
    {ce, equal, minus, plus, dig_vld} = 5'b0;
    dig = 4'd0;
  endtask

  // Let any conversion start, then wait (bounded) for both displays to be valid.
  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 60 && !(vld3 && vld4); i++) begin
      @(posedge clk);
      #1;
    end
    check("settle_vld", {30'd0, vld3, vld4}, 32'd3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_table(input bit four);
    int n;
    vec_t v;
    n = four ? v4.size() : v3.size();
    for (int i = 0; i < n; i++) begin
      v = four ? v4[i] : v3[i];
      press(v.keys, v.dig);
      settle();
      if (four) begin
        check($sformatf("d4_v%0d_state", i), 32'(st4),   32'(v.st));
        check($sformatf("d4_v%0d_cnt", i),   32'(cnt4),  32'(v.cnt));
        check($sformatf("d4_v%0d_sign", i),  32'(sign4), 32'(v.sg));
        check($sformatf("d4_v%0d_ovf", i),   32'(ovf4),  32'(v.ov));
        check($sformatf("d4_v%0d_bcd", i),   32'(bcd4),  32'(v.bcd));
      end else begin
        check($sformatf("d3_v%0d_state", i), 32'(st3),   32'(v.st));
        check($sformatf("d3_v%0d_cnt", i),   32'(cnt3),  32'(v.cnt));
        check($sformatf("d3_v%0d_sign", i),  32'(sign3), 32'(v.sg));
        check($sformatf("d3_v%0d_ovf", i),   32'(ovf3),  32'(v.ov));
        check($sformatf("d3_v%0d_bcd", i),   32'(bcd3),  32'(v.bcd));
      end
    end
  endtask

  initial begin
    int lat3, lat4;
    logic early3, early4;

    // ---- 3-digit table -------------------------------------------------
    // leading zero, entry limit, invalid digit
    add(0, K_D, 0, E, 1, 0, 0, 16'h000);
    add(0, K_D, 4, E, 2, 0, 0, 16'h004);
    add(0, K_D, 5, E, 3, 0, 0, 16'h045);
    add(0, K_D, 7, E, 3, 0, 0, 16'h045);
    add(0, K_CE, 0, E, 0, 0, 0, 16'h000);
    add(0, K_D, 12, E, 0, 0, 0, 16'h000);
    // 123 + 200 = then fresh digit
    add(0, K_D, 1, E, 1, 0, 0, 16'h001);
    add(0, K_D, 2, E, 2, 0, 0, 16'h012);
    add(0, K_D, 3, E, 3, 0, 0, 16'h123);
    add(0, K_P, 0, O, 3, 0, 0, 16'h123);
    add(0, K_D, 2, E, 1, 0, 0, 16'h002);
    add(0, K_D, 0, E, 2, 0, 0, 16'h020);
    add(0, K_D, 0, E, 3, 0, 0, 16'h200);
    add(0, K_EQ, 0, O, 3, 0, 0, 16'h323);
    add(0, K_D, 5, E, 1, 0, 0, 16'h005);
    add(0, K_P, 0, O, 1, 0, 0, 16'h005);
    // 50 - 80 = then operator replacement
    add(0, K_CE, 0, E, 0, 0, 0, 16'h000);
    add(0, K_D, 5, E, 1, 0, 0, 16'h005);
    add(0, K_D, 0, E, 2, 0, 0, 16'h050);
    add(0, K_M, 0, O, 2, 0, 0, 16'h050);
    add(0, K_D, 8, E, 1, 0, 0, 16'h008);
    add(0, K_D, 0, E, 2, 0, 0, 16'h080);
    add(0, K_EQ, 0, O, 2, 1, 0, 16'h030);
    add(0, K_P, 0, O, 2, 1, 0, 16'h030);
    add(0, K_M, 0, O, 2, 1, 0, 16'h030);
    add(0, K_D, 1, E, 1, 0, 0, 16'h001);
    add(0, K_EQ, 0, O, 1, 1, 0, 16'h031);
    add(0, K_EQ, 0, O, 1, 1, 0, 16'h031);
    // 999 + 1 + -> HALT
    add(0, K_CE, 0, E, 0, 0, 0, 16'h000);
    add(0, K_D, 9, E, 1, 0, 0, 16'h009);
    add(0, K_D, 9, E, 2, 0, 0, 16'h099);
    add(0, K_D, 9, E, 3, 0, 0, 16'h999);
    add(0, K_P, 0, O, 3, 0, 0, 16'h999);
    add(0, K_D, 1, E, 1, 0, 0, 16'h001);
    add(0, K_P, 0, H, 1, 0, 1, 16'h000);
    add(0, K_D, 3, H, 1, 0, 1, 16'h000);
    add(0, K_M, 0, H, 1, 0, 1, 16'h000);
    add(0, K_CE, 0, E, 0, 0, 0, 16'h000);
    add(0, K_D, 7, E, 1, 0, 0, 16'h007);
    add(0, K_P, 0, O, 1, 0, 0, 16'h007);
    // ce + plus in one cycle: clear-entry only, accumulator kept
    add(0, K_CE, 0, E, 0, 0, 0, 16'h000);
    add(0, K_D, 4, E, 1, 0, 0, 16'h004);
    add(0, K_P, 0, O, 1, 0, 0, 16'h004);
    add(0, K_D, 1, E, 1, 0, 0, 16'h001);
    add(0, K_D, 2, E, 2, 0, 0, 16'h012);
    add(0, K_CE | K_P, 0, E, 0, 0, 0, 16'h000);
    add(0, K_P, 0, O, 0, 0, 0, 16'h004);

    // ---- 4-digit table -------------------------------------------------
    add(1, K_D, 0, E, 1, 0, 0, 16'h0000);
    add(1, K_D, 4, E, 2, 0, 0, 16'h0004);
    add(1, K_D, 5, E, 3, 0, 0, 16'h0045);
    add(1, K_D, 7, E, 4, 0, 0, 16'h0457);
    add(1, K_D, 8, E, 4, 0, 0, 16'h0457);
    add(1, K_CE, 0, E, 0, 0, 0, 16'h0000);
    add(1, K_D, 9, E, 1, 0, 0, 16'h0009);
    add(1, K_D, 9, E, 2, 0, 0, 16'h0099);
    add(1, K_D, 9, E, 3, 0, 0, 16'h0999);
    add(1, K_D, 9, E, 4, 0, 0, 16'h9999);
    add(1, K_P, 0, O, 4, 0, 0, 16'h9999);
    add(1, K_D, 1, E, 1, 0, 0, 16'h0001);
    add(1, K_P, 0, H, 1, 0, 1, 16'h0000);
    add(1, K_D, 2, H, 1, 0, 1, 16'h0000);
    add(1, K_CE, 0, E, 0, 0, 0, 16'h0000);

    // ---- reset values --------------------------------------------------
    #12;
    check("rst_state", 32'(st3), 32'd0);
    check("rst_cnt", 32'(cnt3), 32'd0);
    check("rst_sign", 32'(sign3), 32'd0);
    check("rst_ovf", 32'(ovf3), 32'd0);
    check("rst_bcd", 32'(bcd3), 32'd0);
    check("rst_vld", 32'(vld3), 32'd1);
    check("rst_bcd4", 32'(bcd4), 32'd0);
    check("rst_vld4", 32'(vld4), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    run_table(0);

    // ---- conversion latency from a fresh reset -------------------------
    do_reset();
    press(K_D, 4);
    lat3 = 0; lat4 = 0; early3 = 1'b1; early4 = 1'b1;
    for (int n = 1; n <= 40 && (lat3 == 0 || lat4 == 0); n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin early3 = vld3; early4 = vld4; end
      if (vld3 && lat3 == 0) lat3 = n;
      if (vld4 && lat4 == 0) lat4 = n;
    end
    check("lat_drop3", 32'(early3), 32'd0);
    check("lat_drop4", 32'(early4), 32'd0);
    check("lat3", 32'(lat3), 32'd11);
    check("lat4", 32'(lat4), 32'd15);
    check("lat_bcd3", 32'(bcd3), 32'h004);
    check("lat_bcd4", 32'(bcd4), 32'h0004);

    // ---- digit pressed mid-conversion restarts it ----------------------
    press(K_D, 1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_vld3", 32'(vld3), 32'd0);
    check("mid_hold3", 32'(bcd3), 32'h004);
    press(K_D, 2);
    lat3 = 0;
    for (int n = 1; n <= 40 && lat3 == 0; n++) begin
      @(posedge clk);
      #1;
      if (vld3) lat3 = n;
    end
    check("restart_lat3", 32'(lat3), 32'd11);
    check("restart_bcd3", 32'(bcd3), 32'h412);
    settle();
    check("restart_bcd4", 32'(bcd4), 32'h0412);

    // ---- async reset mid-conversion ------------------------------------
    press(K_P, 0);
    settle();
    check("pre_rst_state3", 32'(st3), 32'd1);
    press(K_D, 7);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_vld3", 32'(vld3), 32'd0);
    check("pre_rst_hold3", 32'(bcd3), 32'h412);
    #3;
    reset = 1'b0;
    #1;
    check("arst_bcd3", 32'(bcd3), 32'd0);
    check("arst_vld3", 32'(vld3), 32'd1);
    check("arst_state3", 32'(st3), 32'd0);
    check("arst_cnt3", 32'(cnt3), 32'd0);
    check("arst_bcd4", 32'(bcd4), 32'd0);
    check("arst_vld4", 32'(vld4), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_table(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
